// File: rtl/key_press_gen_module.sv
// key_press_gen_module
// Transmit end of the virtual-key path. On each accepted press request the
// pin is driven low for a programmable hold time. Both edges may carry
// contact-bounce glitches. A quiet gap follows, and Done_Sig pulses once
// at the end of that gap.
//
// Handshake: Press_Req is a one-cycle request sampled only in IDLE (Busy=0).
// An accepted request starts the press on the next edge and raises Busy.
// Requests arriving while Busy=1 (guard, press, gap, Done cycle) are dropped
// and are never queued. Done_Sig marks the last busy cycle of each accepted
// request.
module key_press_gen_module #(
  parameter logic [12:0] T100US   = 13'd4_999,  // post-reset guard, cycles-1
  parameter logic [15:0] T1MS     = 16'd49_999, // one millisecond, cycles-1
  parameter logic [15:0] T_BOUNCE = 16'd9_999,  // bounce half-glitch, cycles-1
  parameter logic [2:0]  BOUNCE_N = 3'd2,       // glitches per edge, 0 = clean
  parameter logic [7:0]  GAP_MS   = 8'd10       // idle-high time before Done
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Press_Req,
  input  logic [7:0] Hold_Ms,
  output logic       Pin_Out,
  output logic       Busy,
  output logic       Done_Sig,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    S_GUARD  = 3'd0,
    S_IDLE   = 3'd1,
    S_BNC_DN = 3'd2,
    S_HOLD   = 3'd3,
    S_BNC_UP = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  localparam logic [15:0] GUARD_END  = {3'b000, T100US};
  localparam logic [2:0]  GL_LAST    = BOUNCE_N - 3'd1;
  localparam logic [7:0]  GAP_LAST   = GAP_MS - 8'd1;
  localparam logic        HAS_BOUNCE = (BOUNCE_N != 3'd0);
  localparam logic        ZERO_GAP   = (GAP_MS == 8'd0);

  state_t      state, state_n;
  logic [15:0] sub_cnt, sub_n;     // cycle counter, wraps at T1MS or T_BOUNCE
  logic [7:0]  ms_cnt, ms_n;       // milliseconds elapsed in HOLD / GAP
  logic [2:0]  gl_cnt, gl_n;       // completed glitches on the current edge
  logic        phase, phase_n;     // 0 = first half of a glitch, 1 = second
  logic [7:0]  hold_ms, hold_n;    // latched press length, never 0
  logic        pin_n;

  logic        bnc_wrap;
  logic        ms_wrap;
  logic        gap_end;

  assign bnc_wrap = (sub_cnt == T_BOUNCE);
  assign ms_wrap  = (sub_cnt == T1MS);
  // With a zero-length gap the single settled-high cycle is also the Done cycle.
  assign gap_end  = (state == S_GAP) &&
                    (ZERO_GAP || (ms_wrap && (ms_cnt == GAP_LAST)));

  assign Busy      = (state != S_IDLE);
  assign Done_Sig  = gap_end;
  assign fsm_state = state;

  // State and counter registers; reset forces the pin high without a clock.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_GUARD;
      sub_cnt <= 16'd0;
      ms_cnt  <= 8'd0;
      gl_cnt  <= 3'd0;
      phase   <= 1'b0;
      hold_ms <= 8'd1;
      Pin_Out <= 1'b1;
    end else begin
      state   <= state_n;
      sub_cnt <= sub_n;
      ms_cnt  <= ms_n;
      gl_cnt  <= gl_n;
      phase   <= phase_n;
      hold_ms <= hold_n;
      Pin_Out <= pin_n;
    end
  end

  // Next-state and counter sequencing for guard, press, bounce and gap.
  always_comb begin
    state_n = state;
    sub_n   = sub_cnt;
    ms_n    = ms_cnt;
    gl_n    = gl_cnt;
    phase_n = phase;
    hold_n  = hold_ms;

    case (state)
      S_GUARD: begin
        if (sub_cnt == GUARD_END) begin
          state_n = S_IDLE;
          sub_n   = 16'd0;
        end else begin
          sub_n = sub_cnt + 16'd1;
        end
      end

      S_IDLE: begin
        if (Press_Req) begin
          hold_n  = (Hold_Ms == 8'd0) ? 8'd1 : Hold_Ms;
          sub_n   = 16'd0;
          ms_n    = 8'd0;
          gl_n    = 3'd0;
          phase_n = 1'b0;
          state_n = HAS_BOUNCE ? S_BNC_DN : S_HOLD;
        end
      end

      S_BNC_DN, S_BNC_UP: begin
        if (bnc_wrap) begin
          sub_n = 16'd0;
          if (!phase) begin
            phase_n = 1'b1;
          end else begin
            phase_n = 1'b0;
            if (gl_cnt == GL_LAST) begin
              gl_n    = 3'd0;
              state_n = (state == S_BNC_DN) ? S_HOLD : S_GAP;
            end else begin
              gl_n = gl_cnt + 3'd1;
            end
          end
        end else begin
          sub_n = sub_cnt + 16'd1;
        end
      end

      S_HOLD: begin
        if (ms_wrap) begin
          sub_n = 16'd0;
          if (ms_cnt == (hold_ms - 8'd1)) begin
            ms_n    = 8'd0;
            state_n = HAS_BOUNCE ? S_BNC_UP : S_GAP;
          end else begin
            ms_n = ms_cnt + 8'd1;
          end
        end else begin
          sub_n = sub_cnt + 16'd1;
        end
      end

      S_GAP: begin
        if (gap_end) begin
          state_n = S_IDLE;
          sub_n   = 16'd0;
          ms_n    = 8'd0;
        end else if (ms_wrap) begin
          sub_n = 16'd0;
          ms_n  = ms_cnt + 8'd1;
        end else begin
          sub_n = sub_cnt + 16'd1;
        end
      end

      default: begin
        state_n = S_GUARD;
        sub_n   = 16'd0;
        ms_n    = 8'd0;
        gl_n    = 3'd0;
        phase_n = 1'b0;
      end
    endcase
  end

  // Pin level for the coming cycle, decoded from the next state and glitch phase.
  always_comb begin
    pin_n = 1'b1;
    case (state_n)
      S_BNC_DN: pin_n = phase_n;   // low half first, then high
      S_BNC_UP: pin_n = ~phase_n;  // high half first, then low
      S_HOLD:   pin_n = 1'b0;
      default:  pin_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_key_press_gen_module.sv
// tb_key_press_gen_module
// Directed bench for key_press_gen_module. Instance a has clean edges and
// instance b has two bounce glitches per edge. The expected per-cycle
// {Busy, Done_Sig, Pin_Out} stream is written by hand into exp_q and
// compared one cycle at a time.
module tb_key_press_gen_module;

  logic       CLK = 1'b0;
  logic       RST;
  logic       req_a, req_b;
  logic [7:0] hold_a, hold_b;
  logic       pin_a, busy_a, done_a;
  logic       pin_b, busy_b, done_b;
  logic [2:0] st_a, st_b;

  logic [2:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         falls_b = 0;
  int         rises_b = 0;
  logic       prev_b = 1'b1;
  int         f0, r0;

  key_press_gen_module #(
    .T100US(13'd9), .T1MS(16'd9), .T_BOUNCE(16'd2), .BOUNCE_N(3'd0), .GAP_MS(8'd2)
  ) u_dut_a (
    .CLK(CLK), .RST(RST), .Press_Req(req_a), .Hold_Ms(hold_a),
    .Pin_Out(pin_a), .Busy(busy_a), .Done_Sig(done_a), .fsm_state(st_a)
  );

  key_press_gen_module #(
    .T100US(13'd9), .T1MS(16'd9), .T_BOUNCE(16'd2), .BOUNCE_N(3'd2), .GAP_MS(8'd2)
  ) u_dut_b (
    .CLK(CLK), .RST(RST), .Press_Req(req_b), .Hold_Ms(hold_b),
    .Pin_Out(pin_b), .Busy(busy_b), .Done_Sig(done_b), .fsm_state(st_b)
  );

  // Clock: 10 time-unit period.
  always #5 CLK = ~CLK;

  // Edge counter on instance b, standing in for the receive-side edge detector.
  always @(negedge CLK) begin
    if (prev_b && !pin_b) falls_b++;
    if (!prev_b && pin_b) rises_b++;
    prev_b = pin_b;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic busy, input logic done, input logic pin, input int n);
    repeat (n) exp_q.push_back({busy, done, pin});
  endtask

  task automatic step(input bit sel, input string tag);
    logic [2:0] e;
    logic [2:0] obs;
    @(posedge CLK);
    @(negedge CLK);
    e   = exp_q.pop_front();
    obs = sel ? {busy_b, done_b, pin_b} : {busy_a, done_a, pin_a};
    check(tag, {13'd0, obs}, {13'd0, e});
  endtask

  task automatic drain_n(input bit sel, input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() > 0) step(sel, tag);
    end
  endtask

  task automatic drain_all(input bit sel, input string tag);
    while (exp_q.size() > 0) step(sel, tag);
  endtask

  initial begin
    RST = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    hold_a = 8'd1; hold_b = 8'd1;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_pin_a",  {15'd0, pin_a},  16'd1);
    check("rst_busy_a", {15'd0, busy_a}, 16'd1);
    check("rst_done_a", {15'd0, done_a}, 16'd0);
    check("rst_pin_b",  {15'd0, pin_b},  16'd1);
    check("rst_busy_b", {15'd0, busy_b}, 16'd1);

    // Guard with request held high, then a clean 3 ms press
    RST = 1'b0; req_a = 1'b1; hold_a = 8'd3;
    push(1, 0, 1, 9);      // guard cycles after the release cycle
    push(0, 0, 1, 1);      // first idle cycle
    push(1, 0, 0, 1);      // accepted on the next edge
    drain_all(0, "guard_accept");
    req_a = 1'b0;
    push(1, 0, 0, 29);     // 30 low cycles in total
    push(1, 0, 1, 19);
    push(1, 1, 1, 1);      // Done on the 20th high cycle
    drain_all(0, "hold3_wave");

    // Request in the Done cycle is dropped
    req_a = 1'b1;
    push(0, 0, 1, 1);
    drain_all(0, "done_cycle_req");
    req_a = 1'b0;
    push(0, 0, 1, 2);
    drain_all(0, "idle_after_done");

    // Request pulse during HOLD is dropped
    req_a = 1'b1; hold_a = 8'd2;
    push(1, 0, 0, 20);
    drain_n(0, "hold2_wave", 1);
    req_a = 1'b0;
    drain_n(0, "hold2_wave", 5);
    req_a = 1'b1;
    drain_n(0, "hold2_wave", 1);
    req_a = 1'b0;
    push(1, 0, 1, 19);
    push(1, 1, 1, 1);
    push(0, 0, 1, 3);      // no second press follows
    drain_all(0, "hold2_wave");

    // Hold_Ms=0 behaves as 1 ms
    req_a = 1'b1; hold_a = 8'd0;
    push(1, 0, 0, 10);
    drain_n(0, "hold0_wave", 1);
    req_a = 1'b0;
    push(1, 0, 1, 19);
    push(1, 1, 1, 1);
    push(0, 0, 1, 2);
    drain_all(0, "hold0_wave");

    // Bounced press on instance b
    f0 = falls_b; r0 = rises_b;
    req_b = 1'b1; hold_b = 8'd1;
    push(1, 0, 0, 3); push(1, 0, 1, 3); push(1, 0, 0, 3); push(1, 0, 1, 3);
    push(1, 0, 0, 10);
    push(1, 0, 1, 3); push(1, 0, 0, 3); push(1, 0, 1, 3); push(1, 0, 0, 3);
    push(1, 0, 1, 19);
    push(1, 1, 1, 1);
    push(0, 0, 1, 2);
    drain_n(1, "bounce_wave", 1);
    req_b = 1'b0;
    drain_all(1, "bounce_wave");
    check("bounce_falls", 16'(falls_b - f0), 16'd5);
    check("bounce_rises", 16'(rises_b - r0), 16'd5);

    // Reset mid-HOLD: pin high at once, no Done, guard runs again
    req_a = 1'b1; hold_a = 8'd3;
    push(1, 0, 0, 10);
    drain_n(0, "pre_reset_hold", 1);
    req_a = 1'b0;
    drain_all(0, "pre_reset_hold");
    #2 RST = 1'b1;
    #1;
    check("async_rst_pin",  {15'd0, pin_a},  16'd1);
    check("async_rst_busy", {15'd0, busy_a}, 16'd1);
    check("async_rst_done", {15'd0, done_a}, 16'd0);
    @(negedge CLK);
    RST = 1'b0;
    push(1, 0, 1, 9);
    push(0, 0, 1, 2);
    drain_all(0, "guard_rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
